// File: rtl/lcd_reader.sv
// HD44780 read-cycle engine: one status/data read per start edge, optionally
// repeating status reads until the busy flag clears or the poll budget runs out.
module lcd_reader #(
  parameter int CLK_Divide = 16,
  parameter int SETUP      = 2,
  parameter int HOLD       = 2,
  parameter int POLL_MAX   = 16'hFFFF
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPoll,
  output logic [7:0] oDATA,
  output logic       oBusy,
  output logic       oDone,
  output logic       oTimeout,
  input  logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  localparam int CMAX = (CLK_Divide > SETUP) ? ((CLK_Divide > HOLD) ? CLK_Divide : HOLD)
                                             : ((SETUP > HOLD) ? SETUP : HOLD);
  localparam int CW = $clog2(CMAX + 1);
  localparam int PW = $clog2(POLL_MAX + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP - 1);
  localparam logic [CW-1:0] EN_LAST    = CW'(CLK_Divide - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD - 1);
  localparam logic [PW-1:0] PMAX       = PW'(POLL_MAX);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EN_HI, S_HOLD, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   pollCnt;
  logic            pollQ;
  logic            startPrev;
  logic            startEdge;

  assign startEdge = iStart & ~startPrev;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pollCnt   <= '0;
      pollQ     <= 1'b0;
      startPrev <= 1'b1;  // a start held high through reset release is not an edge
      oDATA     <= '0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oTimeout  <= 1'b0;
      LCD_RW    <= 1'b0;
      LCD_EN    <= 1'b0;
      LCD_RS    <= 1'b0;
    end else begin
      startPrev <= iStart;
      oDone     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (startEdge) begin
            pollQ    <= iPoll & ~iRS;
            oBusy    <= 1'b1;
            LCD_RW   <= 1'b1;
            LCD_RS   <= iRS;
            oTimeout <= 1'b0;
            pollCnt  <= '0;
            cnt      <= '0;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt    <= '0;
            LCD_EN <= 1'b1;
            state  <= S_EN_HI;
          end else cnt <= cnt + 1'b1;
        end
        S_EN_HI: begin
          if (cnt == EN_LAST) begin
            oDATA  <= LCD_DATA;  // sampled while EN is still high
            LCD_EN <= 1'b0;
            if (pollCnt != PMAX) pollCnt <= pollCnt + 1'b1;
            cnt    <= '0;
            state  <= S_HOLD;
          end else cnt <= cnt + 1'b1;
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt <= '0;
            if (pollQ && oDATA[7] && (pollCnt < PMAX)) begin
              state <= S_SETUP;
            end else begin
              if (pollQ && oDATA[7]) oTimeout <= 1'b1;
              oDone  <= 1'b1;
              oBusy  <= 1'b0;
              LCD_RW <= 1'b0;
              LCD_RS <= 1'b0;
              state  <= S_DONE;
            end
          end else cnt <= cnt + 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// Directed bench for lcd_reader: data read, BF polling, poll timeout,
// start-edge abuse and reset during the enable pulse.
module tb_lcd_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0, rs1 = 1'b0, poll1 = 1'b0;
  logic [7:0] data1 = 8'h00;
  logic [7:0] q1;
  logic       busy1, done1, to1, rw1, en1, rsOut1;
  logic       start2 = 1'b0, rs2 = 1'b0, poll2 = 1'b0;
  logic [7:0] data2 = 8'h00;
  logic [7:0] q2;
  logic       busy2, done2, to2, rw2, en2, rsOut2;

  int cmpCnt = 0;
  int errCnt = 0;

  always #5 clk = ~clk;

  lcd_reader dut1 (
    .iCLK(clk), .iRST(rst), .iStart(start1), .iRS(rs1), .iPoll(poll1),
    .oDATA(q1), .oBusy(busy1), .oDone(done1), .oTimeout(to1),
    .LCD_DATA(data1), .LCD_RW(rw1), .LCD_EN(en1), .LCD_RS(rsOut1)
  );

  lcd_reader #(.POLL_MAX(3)) dut2 (
    .iCLK(clk), .iRST(rst), .iStart(start2), .iRS(rs2), .iPoll(poll2),
    .oDATA(q2), .oBusy(busy2), .oDone(done2), .oTimeout(to2),
    .LCD_DATA(data2), .LCD_RW(rw2), .LCD_EN(en2), .LCD_RS(rsOut2)
  );

  task automatic kick(input bit sel);
    repeat (2) @(posedge clk);
    #1;
    if (sel) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    if (sel) start2 = 1'b0; else start1 = 1'b0;
  endtask

  // Observes one operation cycle by cycle (k = clocks after the start edge),
  // feeds the next data byte after each EN pulse and checks the pin protocol.
  task automatic measure(input bit sel, input int limit, input logic [7:0] dAfter,
                         input int switchAfter, output int doneAt, output int pulses,
                         output int enCyc, output int firstEn, output int rwLow);
    logic en, rw, rs, busy, done, pe, prw, prs;
    doneAt = -1; pulses = 0; enCyc = 0; firstEn = -1; rwLow = 0;
    pe = 1'b0; prw = 1'b0; prs = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk);
      #1;
      en   = sel ? en2 : en1;
      rw   = sel ? rw2 : rw1;
      rs   = sel ? rsOut2 : rsOut1;
      busy = sel ? busy2 : busy1;
      done = sel ? done2 : done1;
      cmpCnt++;
      if (en && !rw) begin
        errCnt++;
        $display("FAIL proto_en_rw: k=%0d EN=%0b RW=%0b, EN needs RW=1", k, en, rw);
      end
      if (en && pe) begin
        cmpCnt++;
        if (rw !== prw || rs !== prs) begin
          errCnt++;
          $display("FAIL proto_stable: k=%0d RW/RS=%0b%0b was %0b%0b while EN high", k, rw, rs, prw, prs);
        end
      end
      if (en) begin
        enCyc++;
        if (firstEn < 0) firstEn = k;
        if (!pe) pulses++;
      end
      if (!en && pe && pulses >= switchAfter) begin
        if (sel) data2 = dAfter; else data1 = dAfter;
      end
      if (busy && !rw) rwLow++;
      pe = en; prw = rw; prs = rs;
      if (done) begin
        doneAt = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    cmpCnt++;
    if ({q1, busy1, done1, to1, rw1, en1, rsOut1} !== 14'h0) begin
      errCnt++;
      $display("FAIL reset_outs: got %h required 0", {q1, busy1, done1, to1, rw1, en1, rsOut1});
    end
    cmpCnt++;
    if ({busy2, rw2, en2} !== 3'b000) begin
      errCnt++;
      $display("FAIL reset_outs2: got %b required 000", {busy2, rw2, en2});
    end
  endtask

  task automatic test_data_read();
    int doneAt, pulses, enCyc, firstEn, rwLow;
    rs1 = 1'b1; poll1 = 1'b0; data1 = 8'h41;
    kick(1'b0);
    cmpCnt++;
    if ({busy1, rw1, rsOut1, en1} !== 4'b1110) begin
      errCnt++;
      $display("FAIL read_start: busy/rw/rs/en=%b required 1110", {busy1, rw1, rsOut1, en1});
    end
    measure(1'b0, 200, 8'h41, 0, doneAt, pulses, enCyc, firstEn, rwLow);
    cmpCnt++;
    if (firstEn !== 2) begin errCnt++; $display("FAIL read_en_start: got %0d required 2", firstEn); end
    cmpCnt++;
    if (enCyc !== 16) begin errCnt++; $display("FAIL read_en_width: got %0d required 16", enCyc); end
    cmpCnt++;
    if (doneAt !== 20) begin errCnt++; $display("FAIL read_latency: got %0d required 20", doneAt); end
    cmpCnt++;
    if (q1 !== 8'h41) begin errCnt++; $display("FAIL read_data: got %h required 41", q1); end
    cmpCnt++;
    if ({to1, busy1, rw1, rsOut1} !== 4'b0000) begin
      errCnt++;
      $display("FAIL read_end: to/busy/rw/rs=%b required 0000", {to1, busy1, rw1, rsOut1});
    end
    @(posedge clk); #1;
    cmpCnt++;
    if (done1 !== 1'b0) begin errCnt++; $display("FAIL read_done_pulse: got %b required 0", done1); end
  endtask

  task automatic test_poll();
    int doneAt, pulses, enCyc, firstEn, rwLow;
    rs1 = 1'b0; poll1 = 1'b1; data1 = 8'h80;
    kick(1'b0);
    measure(1'b0, 400, 8'h05, 3, doneAt, pulses, enCyc, firstEn, rwLow);
    cmpCnt++;
    if (pulses !== 4) begin errCnt++; $display("FAIL poll_pulses: got %0d required 4", pulses); end
    cmpCnt++;
    if (doneAt !== 80) begin errCnt++; $display("FAIL poll_latency: got %0d required 80", doneAt); end
    cmpCnt++;
    if (q1 !== 8'h05) begin errCnt++; $display("FAIL poll_data: got %h required 05", q1); end
    cmpCnt++;
    if (rwLow !== 0) begin errCnt++; $display("FAIL poll_rw_held: RW low %0d busy cycles required 0", rwLow); end
    cmpCnt++;
    if (to1 !== 1'b0) begin errCnt++; $display("FAIL poll_timeout: got %b required 0", to1); end
    poll1 = 1'b0;
  endtask

  task automatic test_timeout();
    int doneAt, pulses, enCyc, firstEn, rwLow;
    rs2 = 1'b0; poll2 = 1'b1; data2 = 8'hFF;
    kick(1'b1);
    measure(1'b1, 400, 8'hFF, 0, doneAt, pulses, enCyc, firstEn, rwLow);
    cmpCnt++;
    if (pulses !== 3) begin errCnt++; $display("FAIL to_pulses: got %0d required 3", pulses); end
    cmpCnt++;
    if (doneAt !== 60) begin errCnt++; $display("FAIL to_latency: got %0d required 60", doneAt); end
    cmpCnt++;
    if (to2 !== 1'b1) begin errCnt++; $display("FAIL to_flag: got %b required 1", to2); end
    cmpCnt++;
    if (q2 !== 8'hFF) begin errCnt++; $display("FAIL to_data: got %h required FF", q2); end
    repeat (5) @(posedge clk); #1;
    cmpCnt++;
    if (to2 !== 1'b1) begin errCnt++; $display("FAIL to_held: got %b required 1", to2); end
    rs2 = 1'b1; poll2 = 1'b0; data2 = 8'h33;
    kick(1'b1);
    cmpCnt++;
    if (to2 !== 1'b0) begin errCnt++; $display("FAIL to_clear: got %b required 0", to2); end
    measure(1'b1, 200, 8'h33, 0, doneAt, pulses, enCyc, firstEn, rwLow);
    cmpCnt++;
    if (doneAt !== 20 || q2 !== 8'h33) begin
      errCnt++;
      $display("FAIL to_next_read: doneAt=%0d data=%h required 20/33", doneAt, q2);
    end
  endtask

  task automatic test_start_abuse();
    int dones, busyLate, ens;
    logic pe;
    rs1 = 1'b1; poll1 = 1'b0; data1 = 8'h5A;
    repeat (2) @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;  // start edge
    dones = 0; busyLate = 0; ens = 0; pe = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
      if (done1) dones++;
      if (k > 21 && busy1) busyLate++;
      if (en1 && !pe) ens++;
      pe = en1;
      start1 = !((k >= 5 && k <= 6) || k == 19 || k >= 50);
    end
    cmpCnt++;
    if (dones !== 1) begin errCnt++; $display("FAIL abuse_ops: got %0d dones required 1", dones); end
    cmpCnt++;
    if (ens !== 1) begin errCnt++; $display("FAIL abuse_en: got %0d EN pulses required 1", ens); end
    cmpCnt++;
    if (busyLate !== 0) begin errCnt++; $display("FAIL abuse_restart: busy %0d cycles after done required 0", busyLate); end
    // iStart high across reset release
    start1 = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    busyLate = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (busy1 || en1 || rw1) busyLate++;
    end
    cmpCnt++;
    if (busyLate !== 0) begin errCnt++; $display("FAIL abuse_reset_start: active %0d cycles required 0", busyLate); end
    start1 = 1'b0;
  endtask

  task automatic test_reset_mid_en();
    int doneAt, pulses, enCyc, firstEn, rwLow, spurious;
    rs1 = 1'b1; poll1 = 1'b0; data1 = 8'hC3;
    kick(1'b0);
    repeat (7) @(posedge clk);
    #1;
    cmpCnt++;
    if (en1 !== 1'b1) begin errCnt++; $display("FAIL mid_en_pre: EN=%b required 1", en1); end
    rst = 1'b1;
    #1;
    cmpCnt++;
    if ({en1, rw1, busy1} !== 3'b000) begin
      errCnt++;
      $display("FAIL mid_en_drop: en/rw/busy=%b required 000", {en1, rw1, busy1});
    end
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    spurious = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done1 || busy1) spurious++;
    end
    cmpCnt++;
    if (spurious !== 0) begin errCnt++; $display("FAIL mid_en_nodone: %0d active cycles required 0", spurious); end
    kick(1'b0);
    measure(1'b0, 200, 8'hC3, 0, doneAt, pulses, enCyc, firstEn, rwLow);
    cmpCnt++;
    if (doneAt !== 20 || q1 !== 8'hC3) begin
      errCnt++;
      $display("FAIL mid_en_recover: doneAt=%0d data=%h required 20/C3", doneAt, q1);
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    test_data_read();
    test_poll();
    test_timeout();
    test_start_abuse();
    test_reset_mid_en();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule
